dec_pol_scan: RTL

Parametrised, registered N-to-2^N one-hot decoder with runtime output polarity. It is the sequential successor to the team's 2-to-4 polarity decoder. Two modes: manual, where a select code is loaded through a valid/ready handshake and held; and scan, where an internal counter walks the active output across all lines with a programmable dwell. It drives line-select and strobe fabrics such as display digit enables and chip selects.

---
 rtl/dec_pol_scan_if.sv | 29 ++
 rtl/dec_pol_scan.sv | 119 +++++++++++
 2 files changed

// File: rtl/dec_pol_scan_if.sv
// Bundle of the decoder's control, select handshake and decoded-output signals.
// Master drives en/pol/mode_scan and the sel handshake; slave returns the decoded lines and status.
// OUT_W follows SEL_W so both ends always agree on the line count.
interface dec_pol_scan_if #(
    parameter int SEL_W = 2
) ();
    localparam int OUT_W = 2 ** SEL_W;

    logic             en;         // block enable
    logic             pol;        // 1 = active-high one-hot, 0 = active-low
    logic             mode_scan;  // 1 = auto scan, 0 = manual select
    logic             sel_valid;  // manual select code valid
    logic             sel_ready;  // block can accept sel
    logic [SEL_W-1:0] sel;        // manual select code
    logic [OUT_W-1:0] dec_out;    // decoded output lines
    logic             out_valid;  // dec_out asserts a line
    logic [SEL_W-1:0] cur_idx;    // logical index currently decoded
    logic             scan_wrap;  // pulse on scan wrap to index 0

    modport master (
        output en, pol, mode_scan, sel_valid, sel,
        input  sel_ready, dec_out, out_valid, cur_idx, scan_wrap
    );

    modport slave (
        input  en, pol, mode_scan, sel_valid, sel,
        output sel_ready, dec_out, out_valid, cur_idx, scan_wrap
    );
endinterface

// File: rtl/dec_pol_scan.sv
// Registered N-to-2^N one-hot decoder with runtime polarity, manual hold and auto-scan modes.
// Latency: one cycle from an accepted sel, a scan step or a pol change to dec_out.
// Backpressure: sel_ready drops while disabled, scanning or when mode_scan is requested.
//
// Ports: clk, rst (synchronous, active high); bus (slave modport of dec_pol_scan_if)
//   carrying en, pol, mode_scan, sel_valid/sel_ready/sel in, and dec_out, out_valid,
//   cur_idx, scan_wrap out.
module dec_pol_scan #(
    parameter int SEL_W      = 2,
    parameter int DWELL      = 4,
    parameter bit MAP_SWAP01 = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    dec_pol_scan_if.slave  bus
);
    localparam int OUT_W = 2 ** SEL_W;
    localparam int DW_W  = (DWELL > 1) ? $clog2(DWELL) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        SCAN = 2'd2
    } state_t;

    state_t           state;
    state_t           nxt_state;
    logic [SEL_W-1:0] idx;
    logic [SEL_W-1:0] nxt_idx;
    logic [DW_W-1:0]  dwell_cnt;
    logic [DW_W-1:0]  nxt_dwell;
    logic             nxt_wrap;
    logic [OUT_W-1:0] dec_q;
    logic             out_valid_q;
    logic             scan_wrap_q;
    logic             sel_fire;
    logic             last_dwell;

    // Active pattern for index i at polarity p; an inactive request yields the
    // all-off level of that polarity (all-0 active-high, all-1 active-low).
    function automatic logic [OUT_W-1:0] decode(input logic [SEL_W-1:0] i,
                                                input logic             p,
                                                input logic             act);
        logic [OUT_W-1:0] oh;
        oh = '0;
        if (act) begin
            oh[i] = 1'b1;
            if (MAP_SWAP01) begin
                oh[1:0] = {oh[0], oh[1]};
            end
        end
        return p ? oh : ~oh;
    endfunction

    assign bus.sel_ready = bus.en & ~bus.mode_scan & (state != SCAN);
    assign sel_fire      = bus.sel_valid & bus.sel_ready;
    assign last_dwell    = (dwell_cnt == DW_W'(DWELL - 1));

    // Next-state selection; branch order is the transition priority.
    always_comb begin
        nxt_state = state;
        nxt_idx   = idx;
        nxt_dwell = dwell_cnt;
        nxt_wrap  = 1'b0;
        if (!bus.en) begin
            // idx is kept so cur_idx still shows the last line while idle
            nxt_state = IDLE;
            nxt_dwell = '0;
        end else if ((state == IDLE) && bus.mode_scan) begin
            nxt_state = SCAN;
            nxt_idx   = '0;
            nxt_dwell = '0;
        end else if (sel_fire) begin
            nxt_state = HOLD;
            nxt_idx   = bus.sel;
            nxt_dwell = '0;
        end else if ((state == HOLD) && bus.mode_scan) begin
            nxt_state = SCAN;
            nxt_dwell = '0;
        end else if ((state == SCAN) && !bus.mode_scan) begin
            nxt_state = HOLD;
            nxt_dwell = '0;
        end else if (state == SCAN) begin
            if (last_dwell) begin
                nxt_dwell = '0;
                nxt_idx   = idx + SEL_W'(1);
                // flag lands in the same cycle dec_out first shows index 0
                nxt_wrap  = &idx;
            end else begin
                nxt_dwell = dwell_cnt + DW_W'(1);
            end
        end
    end

    // dec_out is built from the next state and the incoming pol, so the register
    // itself is the polarity stage: its reset value 0 is the pol=1 idle level.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            dwell_cnt   <= '0;
            dec_q       <= '0;
            out_valid_q <= 1'b0;
            scan_wrap_q <= 1'b0;
        end else begin
            state       <= nxt_state;
            idx         <= nxt_idx;
            dwell_cnt   <= nxt_dwell;
            dec_q       <= decode(nxt_idx, bus.pol, nxt_state != IDLE);
            out_valid_q <= (nxt_state != IDLE);
            scan_wrap_q <= nxt_wrap;
        end
    end

    assign bus.dec_out   = dec_q;
    assign bus.out_valid = out_valid_q;
    assign bus.cur_idx   = idx;
    assign bus.scan_wrap = scan_wrap_q;
endmodule
